// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-port signals that pass through mem_port_arbiter.
// slave is the arbiter's view. master is the view of the pipeline and memory that surround it.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_valid;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        stall_if;
   logic        stall_dm;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
      output if_rdata, if_valid, dm_rdata, dm_valid, mem_req, mem_we, mem_addr, mem_wdata,
             stall_if, stall_dm
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
      input  if_rdata, if_valid, dm_rdata, dm_valid, mem_req, mem_we, mem_addr, mem_wdata,
             stall_if, stall_dm
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and load/store.
// Data side wins the first conflict, later conflicts alternate. A stuck transfer is aborted by a timeout.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.slave   bus,
   output logic                timeout_err
);

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [16:0] TO_LIM = 17'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, ABORT} state_t;

   state_t      state;
   logic        last_dm;
   logic [15:0] wait_cnt;
   logic [16:0] wait_next;
   logic        elig_if, elig_dm, grant_dm;

   // A requester whose valid is high this cycle is about to drop req, so it is masked.
   assign elig_if   = bus.if_req & ~bus.if_valid;
   assign elig_dm   = bus.dm_req & ~bus.dm_valid;
   assign grant_dm  = elig_dm & (~elig_if | ~last_dm);
   assign wait_next = {1'b0, wait_cnt} + 17'd1;

   assign bus.stall_if = bus.if_req & ~bus.if_valid;
   assign bus.stall_dm = bus.dm_req & ~bus.dm_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         last_dm       <= 1'b0;
         wait_cnt      <= '0;
         timeout_err   <= 1'b0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.if_rdata  <= '0;
         bus.dm_rdata  <= '0;
         bus.if_valid  <= 1'b0;
         bus.dm_valid  <= 1'b0;
      end else begin
         bus.if_valid <= 1'b0;
         bus.dm_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (elig_if || elig_dm) begin
                  bus.mem_req <= 1'b1;
                  wait_cnt    <= '0;
                  last_dm     <= grant_dm;
                  if (grant_dm) begin
                     bus.mem_we    <= bus.dm_we;
                     bus.mem_addr  <= bus.dm_addr;
                     bus.mem_wdata <= bus.dm_wdata;
                     state         <= BUSY_DM;
                  end else begin
                     bus.mem_we    <= 1'b0;
                     bus.mem_addr  <= bus.if_addr;
                     bus.mem_wdata <= '0;
                     state         <= BUSY_IF;
                  end
               end
            end
            BUSY_IF, BUSY_DM: begin
               if (bus.mem_ready) begin
                  bus.mem_req <= 1'b0;
                  state       <= IDLE;
                  if (state == BUSY_IF) begin
                     bus.if_rdata <= bus.mem_rdata;
                     bus.if_valid <= 1'b1;
                  end else begin
                     // Stores leave the last load data in place.
                     if (!bus.mem_we) bus.dm_rdata <= bus.mem_rdata;
                     bus.dm_valid <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_next[15:0];
                  if (TIMEOUT != 0 && wait_next == TO_LIM) begin
                     bus.mem_req <= 1'b0;
                     timeout_err <= 1'b1;
                     state       <= ABORT;
                  end
               end
            end
            ABORT: begin
               // last_dm still names the requester whose transfer was aborted.
               if (last_dm) begin
                  bus.dm_rdata <= '0;
                  bus.dm_valid <= 1'b1;
               end else begin
                  bus.if_rdata <= NOP;
                  bus.if_valid <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares a single variable-latency unified memory port between the fetch stage (instruction reads) and the memory stage (loads/stores) of the 5-stage RV32I pipeline. It arbitrates with data-side priority on the first conflict and alternates on later ones. It drives the memory request/ready handshake and returns read data to the winning requester. It generates per-requester stall signals and traps stuck memory transactions with a timeout.

## Interface
- TIMEOUT, 255: number of consecutive wait cycles (mem_ready low while busy) that aborts a transaction; 0 disables the timeout; maximum 65535.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request; held high with if_addr stable until if_valid.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetched instruction; valid while if_valid is high.
- if_valid  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request; dm_we, dm_addr and dm_wdata are held stable until dm_valid.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_rdata  out  32  load data; valid while dm_valid is high.
- dm_valid  out  1  one-cycle completion pulse for data (loads and stores).
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  32  memory address, registered.
- mem_wdata  out  32  memory write data, registered.
- mem_ready  in  1  memory completes the transfer in any cycle where mem_req and mem_ready are both high.
- mem_rdata  in  32  memory read data; sampled when mem_ready is high.
- stall_if  out  1  if_req & ~if_valid (combinational).
- stall_dm  out  1  dm_req & ~dm_valid (combinational).
- timeout_err  out  1  sticky timeout flag.

## Operation
- States: IDLE, BUSY_IF, BUSY_DM, ABORT.
- Eligibility in IDLE: a requester is eligible if its req is high and its own valid is low in that cycle. This masking prevents re-granting a request the requester is about to drop.
- Grant in IDLE:
  - Only one requester eligible: grant it.
  - Both eligible: grant the one that is not last_grant. last_grant resets to IF, so DM wins the first conflict.
  - On grant: register the address/we/wdata into the mem_* outputs, set mem_req=1, update last_grant, and go to BUSY_IF or BUSY_DM.
  - Fetch grants always drive mem_we=0 and mem_wdata=0.
- BUSY_x with mem_ready=1:
  - Loads and fetches: capture mem_rdata into x_rdata.
  - Stores: dm_rdata keeps its previous value.
  - Set x_valid=1 for the next cycle, mem_req=0, and go to IDLE.
- BUSY_x with mem_ready=0: increment wait_cnt (16-bit, cleared on every grant). If TIMEOUT≠0 and wait_cnt+1 == TIMEOUT, go to ABORT.
- ABORT (one cycle):
  - mem_req=0 and timeout_err=1. timeout_err is sticky and cleared only by rst.
  - Complete the aborted requester with x_valid=1 next cycle. if_rdata = 32'h0000_0013 (NOP); dm_rdata = 0.
  - Go to IDLE.
- x_valid is a single-cycle pulse and never asserts for both requesters in the same cycle.
- A requester that drops req mid-transaction is not supported. The transaction still completes and the valid pulse is still issued.

## Timing
- Zero-wait memory (mem_ready high in the first mem_req cycle):
  - Cycle 0: req sampled in IDLE.
  - Cycle 1: mem_req=1, mem_ready=1.
  - Cycle 2: x_valid=1.
  - Latency is 2 cycles plus N wait cycles.
- Back-to-back requests from the same requester: a new req may be presented from the cycle after valid, giving a 3-cycle minimum issue interval.
- Conflict service: the loser sees its grant in the valid cycle of the winner, since IDLE then masks only the winner.
- mem_* outputs are stable for the whole mem_req-high window.
- Reset values: all outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_valid, dm_valid, timeout_err), state=IDLE, last_grant=IF, wait_cnt=0.
- Reset mid-transaction:
  - mem_req is 0 in the cycle after the rst edge.
  - The in-flight transaction is discarded and no valid pulse is issued.
  - A mem_ready arriving during or after reset is ignored.
- Stall outputs follow req combinationally. They fall in the valid cycle, allowing the pipeline to advance on that edge.

## Test plan
- Reset: assert rst for 2 cycles while mem_ready=1 -> all outputs 0, no mem_req; after release with no req, mem_req stays 0.
- Single fetch: if_req=1, if_addr=0x100, mem_ready rises 3 cycles after mem_req, mem_rdata=0x00500093 -> mem_addr=0x100, mem_we=0; if_valid pulses once at cycle 5 with if_rdata=0x00500093; stall_if is high for cycles 0-4.
- Conflict: if_req and a store request (dm_we=1, dm_addr=0x200, dm_wdata=0xDEADBEEF) rise in the same cycle, zero-wait memory -> DM is granted first (mem_we=1, mem_wdata=0xDEADBEEF); dm_valid pulses; the next grant is the fetch; a second simultaneous conflict is granted to DM again (alternation after IF).
- Load: dm_req=1, dm_we=0, dm_addr=0x40, mem_rdata=0x12345678 after 1 wait cycle -> dm_valid at cycle 3 with dm_rdata=0x12345678; a following store leaves dm_rdata=0x12345678.
- Timeout: TIMEOUT=4, fetch granted, mem_ready held 0 -> ABORT after 4 wait cycles; mem_req drops; if_valid pulses with if_rdata=0x00000013; timeout_err=1 and stays 1 through later successful transactions until rst.
- Reset mid-op: rst asserted during BUSY_DM wait, mem_ready pulsed in the cycle after -> mem_req=0 after the rst edge; no dm_valid; the state is IDLE after release.
